// File: rtl/task2a_fsm.sv
// RC4 key-scheduling (KSA) swap-loop controller driving an external 256x8 S memory.
// The memory is synchronous: address/wren/data are sampled on the rising edge and
// q reflects mem[address] after that edge, so each read holds the address for two
// edges before the data is captured.
//
// state  | meaning
// IDLE   | waiting for start
// RD_I   | present address i to memory
// WT_I   | memory read latency for S[i]
// CAP_I  | capture S[i], update j
// RD_J   | present address j to memory
// WT_J   | memory read latency for S[j]
// CAP_J  | capture S[j]
// WR_I   | write S[j] to address i
// WR_J   | write S[i] to address j
// INC    | advance i or finish the pass
// DONE   | one-cycle finish pulse
module task2a_fsm (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  input  logic [23:0] secret_key,
  input  logic [7:0]  q,
  output logic        finish,
  output logic        wren,
  output logic [7:0]  address,
  output logic [7:0]  data
);

  localparam logic [3:0] IDLE  = 4'd0;
  localparam logic [3:0] RD_I  = 4'd1;
  localparam logic [3:0] WT_I  = 4'd2;
  localparam logic [3:0] CAP_I = 4'd3;
  localparam logic [3:0] RD_J  = 4'd4;
  localparam logic [3:0] WT_J  = 4'd5;
  localparam logic [3:0] CAP_J = 4'd6;
  localparam logic [3:0] WR_I  = 4'd7;
  localparam logic [3:0] WR_J  = 4'd8;
  localparam logic [3:0] INC   = 4'd9;
  localparam logic [3:0] DONE  = 4'd10;

  logic [3:0] state_q, state_d;
  logic [7:0] i_q, i_d;
  logic [7:0] j_q, j_d;
  logic [7:0] si_q, si_d;
  logic [7:0] sj_q, sj_d;
  logic [7:0] data_q, data_d;
  // Tracks i mod 3 alongside i so no modulo hardware is needed.
  logic [1:0] kidx_q, kidx_d;
  logic [7:0] key_byte;

  // Key byte for the current i: byte0 is the most significant byte.
  always_comb begin
    case (kidx_q)
      2'd0:    key_byte = secret_key[23:16];
      2'd1:    key_byte = secret_key[15:8];
      default: key_byte = secret_key[7:0];
    endcase
  end

  // Next-state and datapath update; all sums wrap at 8 bits.
  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    si_d    = si_q;
    sj_d    = sj_q;
    data_d  = data_q;
    kidx_d  = kidx_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          i_d     = 8'd0;
          j_d     = 8'd0;
          kidx_d  = 2'd0;
          state_d = RD_I;
        end
      end
      RD_I:  state_d = WT_I;
      WT_I:  state_d = CAP_I;
      CAP_I: begin
        si_d    = q;
        j_d     = j_q + q + key_byte;
        state_d = RD_J;
      end
      RD_J:  state_d = WT_J;
      WT_J:  state_d = CAP_J;
      CAP_J: begin
        sj_d    = q;
        // data is registered so it is already S[j] while in WR_I.
        data_d  = q;
        state_d = WR_I;
      end
      WR_I: begin
        data_d  = si_q;
        state_d = WR_J;
      end
      WR_J:  state_d = INC;
      INC: begin
        if (i_q == 8'hFF) begin
          state_d = DONE;
        end else begin
          i_d     = i_q + 8'd1;
          kidx_d  = (kidx_q == 2'd2) ? 2'd0 : kidx_q + 2'd1;
          state_d = RD_I;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= IDLE;
      i_q     <= 8'd0;
      j_q     <= 8'd0;
      si_q    <= 8'd0;
      sj_q    <= 8'd0;
      data_q  <= 8'd0;
      kidx_q  <= 2'd0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      si_q    <= si_d;
      sj_q    <= sj_d;
      data_q  <= data_d;
      kidx_q  <= kidx_d;
    end
  end

  // Moore outputs decoded from the registered state.
  always_comb begin
    address = i_q;
    case (state_q)
      RD_J, WT_J, CAP_J, WR_J: address = j_q;
      default:                 address = i_q;
    endcase
    wren   = (state_q == WR_I) || (state_q == WR_J);
    finish = (state_q == DONE);
    data   = data_q;
  end

endmodule

// File: tb/tb_task2a_fsm.sv
// Bench for task2a_fsm: behavioural 256x8 RAM plus a software RC4 KSA reference.
module tb_task2a_fsm;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        start;
  logic [23:0] secret_key;
  logic [7:0]  q;
  logic        finish;
  logic        wren;
  logic [7:0]  address;
  logic [7:0]  data;

  logic [7:0]  mem      [256];
  logic [7:0]  load_img [256];
  logic [7:0]  model_s  [256];
  logic        load_en = 1'b0;
  logic [7:0]  ram_q;
  logic        q_tie_en;
  logic [7:0]  q_tie;
  logic [15:0] wr_log [$];

  int checks = 0;
  int errors = 0;

  task2a_fsm dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .start      (start),
    .secret_key (secret_key),
    .q          (q),
    .finish     (finish),
    .wren       (wren),
    .address    (address),
    .data       (data)
  );

  always #5 clock = ~clock;

  assign q = q_tie_en ? q_tie : ram_q;

  // Synchronous RAM with bulk preload, plus a log of every write it accepts.
  always @(posedge clock) begin
    if (load_en) mem <= load_img;
    else if (wren) mem[address] <= data;
    ram_q <= mem[address];
    if (wren) wr_log.push_back({address, data});
  end

  task automatic tick;
    @(posedge clock);
    @(negedge clock);
  endtask

  function automatic logic [7:0] kb(input logic [23:0] k, input int i);
    case (i % 3)
      0:       return k[23:16];
      1:       return k[15:8];
      default: return k[7:0];
    endcase
  endfunction

  task automatic run_model(input logic [23:0] key);
    int j;
    logic [7:0] t;
    j = 0;
    for (int i = 0; i < 256; i++) begin
      j = (j + int'(model_s[i]) + int'(kb(key, i))) % 256;
      t = model_s[i];
      model_s[i] = model_s[j];
      model_s[j] = t;
    end
  endtask

  task automatic do_load;
    load_en = 1'b1;
    tick;
    load_en = 1'b0;
  endtask

  task automatic load_identity;
    for (int n = 0; n < 256; n++) load_img[n] = n[7:0];
    do_load;
  endtask

  task automatic do_reset;
    reset_n = 1'b0;
    start = 1'b0;
    q_tie_en = 1'b0;
    tick;
    tick;
    reset_n = 1'b1;
    tick;
    wr_log.delete();
  endtask

  // One full pass from the current RAM contents; mid>0 pulses start mid-pass.
  task automatic run_pass(input logic [23:0] key, input int mid, input string tag);
    int fin_cnt;
    int fin_at;
    for (int n = 0; n < 256; n++) model_s[n] = mem[n];
    run_model(key);
    secret_key = key;
    q_tie_en = 1'b0;
    fin_cnt = 0;
    fin_at = -1;
    start = 1'b1;
    for (int c = 1; c <= 2400; c++) begin
      tick;
      start = (c == mid);
      if (finish) begin
        fin_cnt++;
        if (fin_at < 0) fin_at = c;
      end
    end
    start = 1'b0;
    checks++;
    if (fin_cnt != 1) begin
      errors++;
      $display("FAIL %s finish_count: got %0d expected 1", tag, fin_cnt);
    end
    checks++;
    if (fin_at != 2305) begin
      errors++;
      $display("FAIL %s finish_latency: got %0d expected 2305", tag, fin_at);
    end
    for (int n = 0; n < 256; n++) begin
      checks++;
      if (mem[n] !== model_s[n]) begin
        errors++;
        $display("FAIL %s ram[%0d]: got %h expected %h", tag, n, mem[n], model_s[n]);
      end
    end
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    start = 1'b1;
    tick;
    tick;
    checks++;
    if (finish !== 1'b0) begin errors++; $display("FAIL reset_finish: got %b expected 0", finish); end
    checks++;
    if (wren !== 1'b0) begin errors++; $display("FAIL reset_wren: got %b expected 0", wren); end
    checks++;
    if (address !== 8'h00) begin errors++; $display("FAIL reset_address: got %h expected 00", address); end
    checks++;
    if (data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h expected 00", data); end
    start = 1'b0;
    reset_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick;
      checks++;
      if (wren !== 1'b0 || finish !== 1'b0) begin
        errors++;
        $display("FAIL idle_wait: got wren=%b finish=%b expected 0 0", wren, finish);
      end
    end
    wr_log.delete();
  endtask

  task automatic check_writes_tied(input logic [7:0] qv, input logic [23:0] key, input int iters,
                                   input string tag);
    logic [15:0] exp_w [$];
    int j;
    int waited;
    j = 0;
    for (int i = 0; i < iters; i++) begin
      j = (j + int'(qv) + int'(kb(key, i))) % 256;
      exp_w.push_back({i[7:0], qv});
      exp_w.push_back({j[7:0], qv});
    end
    q_tie_en = 1'b1;
    q_tie = qv;
    secret_key = key;
    wr_log.delete();
    start = 1'b1;
    tick;
    start = 1'b0;
    waited = 0;
    while (wr_log.size() < 2 * iters && waited < 12 * iters) begin
      tick;
      waited++;
    end
    checks++;
    if (wr_log.size() < 2 * iters) begin
      errors++;
      $display("FAIL %s write_timeout: got %0d writes expected %0d", tag, wr_log.size(), 2 * iters);
    end else begin
      for (int w = 0; w < 2 * iters; w++) begin
        checks++;
        if (wr_log[w] !== exp_w[w]) begin
          errors++;
          $display("FAIL %s write%0d: got addr %h data %h expected addr %h data %h",
                   tag, w, wr_log[w][15:8], wr_log[w][7:0], exp_w[w][15:8], exp_w[w][7:0]);
        end
      end
    end
    do_reset;
  endtask

  task automatic test_fixed_q;
    check_writes_tied(8'hAF, 24'h000000, 2, "fixed_q");
  endtask

  task automatic test_key_order;
    check_writes_tied(8'h00, 24'h010000, 4, "key_order");
  endtask

  task automatic test_full_run;
    load_identity;
    run_pass(24'h000249, 0, "full_0249");
    do_reset;
    load_identity;
    run_pass(24'($urandom), $urandom_range(2, 2290), "full_rand_midstart");
    do_reset;
  endtask

  task automatic test_reset_midpass;
    logic [23:0] key;
    bit found;
    key = 24'($urandom);
    load_identity;
    secret_key = key;
    q_tie_en = 1'b0;
    wr_log.delete();
    start = 1'b1;
    tick;
    start = 1'b0;
    found = 0;
    for (int c = 0; c < 200 && !found; c++) begin
      if (wren && address == 8'd5 && wr_log.size() == 10) found = 1;
      else tick;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL midpass_reach_wr_i5: got not_found expected found");
    end else begin
      reset_n = 1'b0;
      tick;
      checks++;
      if (wren !== 1'b0) begin errors++; $display("FAIL midpass_wren: got %b expected 0", wren); end
      checks++;
      if (finish !== 1'b0) begin errors++; $display("FAIL midpass_finish: got %b expected 0", finish); end
      checks++;
      if (address !== 8'h00 || data !== 8'h00) begin
        errors++;
        $display("FAIL midpass_outputs: got addr %h data %h expected 00 00", address, data);
      end
      reset_n = 1'b1;
      for (int c = 0; c < 4; c++) begin
        tick;
        checks++;
        if (wren !== 1'b0 || finish !== 1'b0) begin
          errors++;
          $display("FAIL midpass_idle: got wren=%b finish=%b expected 0 0", wren, finish);
        end
      end
      run_pass(key, 0, "restart_after_reset");
    end
    do_reset;
  endtask

  task automatic test_i_eq_j;
    int v;
    int waited;
    logic [7:0] v8;
    logic [7:0] k0;
    v = $urandom_range(1, 255);
    v8 = v[7:0];
    k0 = 8'((256 - v) % 256);
    for (int n = 0; n < 256; n++) load_img[n] = n[7:0];
    load_img[0] = v8;
    load_img[v] = 8'h00;
    do_load;
    secret_key = {k0, 16'($urandom)};
    q_tie_en = 1'b0;
    wr_log.delete();
    start = 1'b1;
    tick;
    start = 1'b0;
    waited = 0;
    while (wr_log.size() < 2 && waited < 30) begin
      tick;
      waited++;
    end
    checks++;
    if (wr_log.size() < 2) begin
      errors++;
      $display("FAIL ieqj_timeout: got %0d writes expected 2", wr_log.size());
    end else begin
      checks++;
      if (wr_log[0] !== {8'h00, v8}) begin
        errors++;
        $display("FAIL ieqj_wr_i: got %h expected %h", wr_log[0], {8'h00, v8});
      end
      checks++;
      if (wr_log[1] !== {8'h00, v8}) begin
        errors++;
        $display("FAIL ieqj_wr_j: got %h expected %h", wr_log[1], {8'h00, v8});
      end
      checks++;
      if (mem[0] !== v8) begin
        errors++;
        $display("FAIL ieqj_ram0: got %h expected %h", mem[0], v8);
      end
    end
    do_reset;
  endtask

  task automatic test_back_to_back;
    logic [23:0] key;
    int fins [$];
    key = 24'($urandom);
    load_identity;
    for (int n = 0; n < 256; n++) model_s[n] = mem[n];
    run_model(key);
    run_model(key);
    secret_key = key;
    q_tie_en = 1'b0;
    start = 1'b1;
    for (int c = 1; c <= 4700; c++) begin
      tick;
      if (finish) fins.push_back(c);
      if (fins.size() >= 2) start = 1'b0;
    end
    start = 1'b0;
    checks++;
    if (fins.size() != 2) begin
      errors++;
      $display("FAIL b2b_finish_count: got %0d expected 2", fins.size());
    end
    checks++;
    if (fins.size() < 1 || fins[0] != 2305) begin
      errors++;
      $display("FAIL b2b_first_finish: got %0d expected 2305", (fins.size() > 0) ? fins[0] : -1);
    end
    checks++;
    if (fins.size() < 2 || fins[1] != 4611) begin
      errors++;
      $display("FAIL b2b_second_finish: got %0d expected 4611", (fins.size() > 1) ? fins[1] : -1);
    end
    for (int n = 0; n < 256; n++) begin
      checks++;
      if (mem[n] !== model_s[n]) begin
        errors++;
        $display("FAIL b2b_ram[%0d]: got %h expected %h", n, mem[n], model_s[n]);
      end
    end
    do_reset;
  endtask

  initial begin
    reset_n = 1'b0;
    start = 1'b0;
    secret_key = 24'h0;
    q_tie_en = 1'b0;
    q_tie = 8'h00;
    for (int n = 0; n < 256; n++) load_img[n] = 8'h00;
    @(negedge clock);
    test_reset;
    test_fixed_q;
    test_key_order;
    test_full_run;
    test_reset_midpass;
    test_i_eq_j;
    test_back_to_back;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
